key_search_ctrl: RTL and testbench
==================================

KEY_SEARCH_CTRL -- requirements
Module: key_search_ctrl

Interface
REQ-001 Parameter KEY_FIRST, default 24'h000000, first key tried.
REQ-002 Parameter KEY_STEP, default 24'h000001, key increment per attempt; must be nonzero.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 en  in  1  start request; honoured only while rdy=1.
REQ-006 rdy  out  1  high when idle and able to accept en.
REQ-007 stop  in  1  abort request, e.g. a parallel searcher has found the key.
REQ-008 key  out  24  last key tried; the winning key when key_valid=1.
REQ-009 key_valid  out  1  high when the last search found a key.
REQ-010 arc4_en  out  1  one-cycle start pulse to the arc4 engine.
REQ-011 arc4_rdy  in  1  arc4 engine ready.
REQ-012 arc4_key  out  24  key presented to the arc4 engine.
REQ-013 pt_addr  in  8  snooped plaintext write address from arc4.
REQ-014 pt_wrdata  in  8  snooped plaintext write data from arc4.
REQ-015 pt_wren  in  1  snooped plaintext write strobe from arc4.

Function
REQ-016 States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, EVAL, DONE.
REQ-017 IDLE: rdy=1; en=1 -> load cand=KEY_FIRST, clear key_valid, clear bad and stop_seen, go to LAUNCH.
REQ-018 LAUNCH: when arc4_rdy=1, assert arc4_en for exactly one cycle and go to WAIT_BUSY; otherwise hold with arc4_en=0.
REQ-019 WAIT_BUSY: wait until arc4_rdy=0, then go to WAIT_DONE; arc4_en=0.
REQ-020 WAIT_DONE: wait until arc4_rdy=1, then go to EVAL.
REQ-021 arc4_key SHALL equal cand continuously from LAUNCH through EVAL.
REQ-022 Plaintext checking is active in WAIT_BUSY and WAIT_DONE on every cycle with pt_wren=1.
REQ-023 A write with pt_addr=0 carries the message length byte and is not checked.
REQ-024 A write with pt_addr!=0 and pt_wrdata outside 8'h20..8'h7E inclusive sets bad.
REQ-025 Once set, bad stays set until the next LAUNCH clears it.
REQ-026 EVAL, bad=0: key<=cand, key_valid<=1, go to DONE.
REQ-027 EVAL, bad=1 and (stop_seen=1 or cand+KEY_STEP overflows 24 bits): key<=cand, key_valid<=0, go to DONE.
REQ-028 EVAL, otherwise: cand<=cand+KEY_STEP, go to LAUNCH.
REQ-029 Overflow test uses a 25-bit sum; a carry out of bit 23 means the key space is exhausted.
REQ-030 stop=1 in any non-IDLE state sets stop_seen; the arc4 run in flight is always completed and evaluated, never cut short.
REQ-031 stop=1 in IDLE is ignored.
REQ-032 DONE: rdy=1 for one cycle, then go to IDLE; key and key_valid hold until the next accepted en.
REQ-033 en=1 in DONE is accepted exactly as in IDLE.
REQ-034 en while rdy=0 is ignored.
REQ-035 key_valid=1 when stop arrives in the same attempt: the find wins over the stop.

Reset
REQ-036 rst_n=0 at a clock edge: state=IDLE, cand=KEY_FIRST, key=0, key_valid=0, bad=0, stop_seen=0, arc4_en=0; rdy=1 from the first cycle after reset.
REQ-037 Reset mid-search abandons the search immediately; the arc4 engine is reset by the same rst_n.

Verification
REQ-038 Stub arc4 writes pt[0]=5 then "Hello" for key 24'h000003 and byte 8'h01 at addr 1 for other keys; en with defaults -> four arc4_en pulses for keys 0..3, then key=24'h000003, key_valid=1, rdy=1.
REQ-039 KEY_FIRST=1, KEY_STEP=2, same stub -> keys 1,3 tried; key=24'h000003, key_valid=1.
REQ-040 KEY_FIRST=24'hFFFFFE, stub always bad -> keys FFFFFE and FFFFFF tried; key=24'hFFFFFF, key_valid=0, no wrap to 0.
REQ-041 Stub always bad, stop pulsed during the third run -> third run finishes; key=24'h000002, key_valid=0, no fourth arc4_en.
REQ-042 arc4_rdy held low 10 cycles after reset -> no arc4_en until arc4_rdy=1; pt byte 8'h7F at addr 2 -> attempt rejected; 8'h7F at addr 0 -> accepted as length.
REQ-043 rst_n=0 during WAIT_DONE -> next cycle rdy=1, key=0, key_valid=0, arc4_en=0.

Source files
------------

// File: rtl/key_search_ctrl.sv
// Brute-force key search sequencer: walks candidate keys through an external arc4
// engine and snoops its plaintext writes to accept or reject each candidate.
module key_search_ctrl #(
  parameter logic [23:0] KEY_FIRST = 24'h000000,
  parameter logic [23:0] KEY_STEP  = 24'h000001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        rdy,
  input  logic        stop,
  output logic [23:0] key,
  output logic        key_valid,
  output logic        arc4_en,
  input  logic        arc4_rdy,
  output logic [23:0] arc4_key,
  input  logic [7:0]  pt_addr,
  input  logic [7:0]  pt_wrdata,
  input  logic        pt_wren
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_EVAL,
    S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [23:0] cand;
  logic        bad;
  logic        stop_seen;
  logic [24:0] cand_sum;
  logic        exhausted;
  logic        finish;
  logic        snoop_bad;

  // Carry out of bit 23 means the next candidate would wrap: key space exhausted.
  assign cand_sum  = {1'b0, cand} + {1'b0, KEY_STEP};
  assign exhausted = cand_sum[24];
  assign finish    = !bad || stop_seen || exhausted;

  // Address 0 holds the length byte, so only the message body must be printable.
  assign snoop_bad = pt_wren && (pt_addr != 8'h00) &&
                     ((pt_wrdata < 8'h20) || (pt_wrdata > 8'h7E));

  assign arc4_key = cand;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values; reset here is synchronous, matching the arc4 engine.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    arc4_en   = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        rdy       = 1'b1;
        state_nxt = en ? S_LAUNCH : S_IDLE;
      end
      S_LAUNCH: begin
        if (arc4_rdy) begin
          arc4_en   = 1'b1;
          state_nxt = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: if (!arc4_rdy) state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (arc4_rdy)  state_nxt = S_EVAL;
      S_EVAL:      state_nxt = finish ? S_DONE : S_LAUNCH;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cand      <= KEY_FIRST;
      key       <= '0;
      key_valid <= 1'b0;
      bad       <= 1'b0;
      stop_seen <= 1'b0;
    end else begin
      // An abort is only latched; the run in flight still completes and is judged.
      if (stop && (state != S_IDLE)) stop_seen <= 1'b1;
      case (state)
        S_IDLE, S_DONE: begin
          if (en) begin
            cand      <= KEY_FIRST;
            key_valid <= 1'b0;
            bad       <= 1'b0;
            stop_seen <= 1'b0;
          end
        end
        S_LAUNCH: bad <= 1'b0;
        S_WAIT_BUSY, S_WAIT_DONE: if (snoop_bad) bad <= 1'b1;
        S_EVAL: begin
          if (finish) begin
            key       <= cand;
            key_valid <= !bad;
          end else begin
            cand <= cand_sum[23:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_key_search_ctrl.sv
// Directed bench for key_search_ctrl: three parameterisations share one arc4 stub,
// which serves whichever instance is selected for the current test.
module tb_key_search_ctrl;

  logic        clk;
  logic        rst_n;
  logic [2:0]  en_v;
  logic        stop;
  logic [2:0]  rdy_v;
  logic [2:0]  key_valid_v;
  logic [2:0]  arc4_en_v;
  logic [23:0] key_v      [3];
  logic [23:0] arc4_key_v [3];

  logic        arc4_rdy;
  logic [7:0]  pt_addr;
  logic [7:0]  pt_wrdata;
  logic        pt_wren;

  int          sel;
  int          stub_mode;
  int          stub_hold;
  int          hold_cnt;
  int          idx;
  logic        busy;
  logic [23:0] run_key;

  int          n_pulse;
  logic [23:0] tried [16];

  int          n_vec;
  int          n_err;

  key_search_ctrl u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en_v[0]), .rdy(rdy_v[0]), .stop(stop),
    .key(key_v[0]), .key_valid(key_valid_v[0]), .arc4_en(arc4_en_v[0]),
    .arc4_rdy(arc4_rdy), .arc4_key(arc4_key_v[0]),
    .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren)
  );

  key_search_ctrl #(.KEY_FIRST(24'h000001), .KEY_STEP(24'h000002)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en_v[1]), .rdy(rdy_v[1]), .stop(stop),
    .key(key_v[1]), .key_valid(key_valid_v[1]), .arc4_en(arc4_en_v[1]),
    .arc4_rdy(arc4_rdy), .arc4_key(arc4_key_v[1]),
    .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren)
  );

  key_search_ctrl #(.KEY_FIRST(24'hFFFFFE), .KEY_STEP(24'h000001)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en_v[2]), .rdy(rdy_v[2]), .stop(stop),
    .key(key_v[2]), .key_valid(key_valid_v[2]), .arc4_en(arc4_en_v[2]),
    .arc4_rdy(arc4_rdy), .arc4_key(arc4_key_v[2]),
    .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub plaintext: mode 0 = "Hello" for key 3, mode 1 = always bad,
  // mode 2 = key 0 ends in 7F at addr 2, other keys put 7F in the length slot.
  function automatic int msg_len(input int mode, input logic [23:0] k);
    if (mode == 0 && k == 24'd3) return 6;
    if (mode == 2) return 3;
    return 2;
  endfunction

  function automatic logic [15:0] msg_byte(input int mode, input logic [23:0] k, input int i);
    logic [7:0] d;
    logic [7:0] a;
    a = i[7:0];
    d = 8'h01;
    if (i == 0) d = (mode == 2 && k != 24'd0) ? 8'h7F : 8'h05;
    else if (mode == 0 && k == 24'd3) begin
      case (i)
        1:       d = 8'h48;
        2:       d = 8'h65;
        3, 4:    d = 8'h6C;
        default: d = 8'h6F;
      endcase
    end else if (mode == 2) begin
      if (k == 24'd0) d = (i == 1) ? 8'h41 : 8'h7F;
      else            d = (i == 1) ? 8'h7E : 8'h20;
    end
    return {a, d};
  endfunction

  assign arc4_rdy = !busy && (hold_cnt == 0);

  always @(posedge clk) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      idx       <= 0;
      hold_cnt  <= stub_hold;
      pt_wren   <= 1'b0;
      pt_addr   <= 8'h00;
      pt_wrdata <= 8'h00;
      run_key   <= 24'h0;
    end else if (hold_cnt != 0) begin
      hold_cnt <= hold_cnt - 1;
    end else if (!busy) begin
      pt_wren <= 1'b0;
      if (arc4_en_v[sel]) begin
        busy    <= 1'b1;
        run_key <= arc4_key_v[sel];
        idx     <= 0;
      end
    end else if (idx == msg_len(stub_mode, run_key)) begin
      busy    <= 1'b0;
      pt_wren <= 1'b0;
    end else begin
      pt_wren              <= 1'b1;
      {pt_addr, pt_wrdata} <= msg_byte(stub_mode, run_key, idx);
      idx                  <= idx + 1;
    end
  end

  always @(posedge clk) begin
    if (!rst_n) n_pulse <= 0;
    else if (arc4_en_v[sel]) begin
      if (n_pulse < 16) tried[n_pulse[3:0]] <= arc4_key_v[sel];
      n_pulse <= n_pulse + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input int s, input int mode, input int hold);
    @(negedge clk);
    rst_n     = 1'b0;
    sel       = s;
    stub_mode = mode;
    stub_hold = hold;
    en_v      = 3'b000;
    stop      = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic start(input logic with_stop);
    en_v[sel] = 1'b1;
    stop      = with_stop;
    @(negedge clk);
    en_v = 3'b000;
    stop = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy_v[sel] && n < 600);
    check({tag, "_done"}, 32'(rdy_v[sel]), 32'd1);
  endtask

  task automatic wait_pulses(input string tag, input int want);
    int n;
    n = 0;
    while (n_pulse < want && n < 600) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_reach"}, 32'(n_pulse), 32'(want));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    en_v  = 3'b000;
    stop  = 1'b0;
    sel   = 0;
    stub_mode = 0;
    stub_hold = 0;

    // Reset state of all three instances
    do_reset(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_rdy%0d", i),   32'(rdy_v[i]),       32'd1);
      check($sformatf("rst_key%0d", i),   32'(key_v[i]),       32'd0);
      check($sformatf("rst_kv%0d", i),    32'(key_valid_v[i]), 32'd0);
      check($sformatf("rst_a4en%0d", i),  32'(arc4_en_v[i]),   32'd0);
    end

    // Default search; stop alongside en in IDLE must be ignored, en while busy too
    start(1'b1);
    check("b_busy", 32'(rdy_v[0]), 32'd0);
    repeat (5) @(negedge clk);
    en_v[0] = 1'b1;
    @(negedge clk);
    en_v = 3'b000;
    wait_done("b");
    check("b_pulses", 32'(n_pulse), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("b_try%0d", i), 32'(tried[i]), 32'(i));
    check("b_key", 32'(key_v[0]), 32'h000003);
    check("b_kv",  32'(key_valid_v[0]), 32'd1);
    repeat (4) @(negedge clk);
    check("b_hold_key", 32'(key_v[0]), 32'h000003);
    check("b_hold_kv",  32'(key_valid_v[0]), 32'd1);
    check("b_idle_rdy", 32'(rdy_v[0]), 32'd1);

    // KEY_FIRST=1, KEY_STEP=2
    do_reset(1, 0, 0);
    start(1'b0);
    wait_done("c");
    check("c_pulses", 32'(n_pulse), 32'd2);
    check("c_try0", 32'(tried[0]), 32'h000001);
    check("c_try1", 32'(tried[1]), 32'h000003);
    check("c_key",  32'(key_v[1]), 32'h000003);
    check("c_kv",   32'(key_valid_v[1]), 32'd1);

    // Top of key space, always bad: no wrap to 0
    do_reset(2, 1, 0);
    start(1'b0);
    wait_done("d");
    check("d_pulses", 32'(n_pulse), 32'd2);
    check("d_try0", 32'(tried[0]), 32'hFFFFFE);
    check("d_try1", 32'(tried[1]), 32'hFFFFFF);
    check("d_key",  32'(key_v[2]), 32'hFFFFFF);
    check("d_kv",   32'(key_valid_v[2]), 32'd0);

    // Stop during third run of an always-bad search
    do_reset(0, 1, 0);
    start(1'b0);
    wait_pulses("e", 3);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_done("e");
    check("e_key", 32'(key_v[0]), 32'h000002);
    check("e_kv",  32'(key_valid_v[0]), 32'd0);
    repeat (6) @(negedge clk);
    check("e_pulses", 32'(n_pulse), 32'd3);

    // Stop during the winning run: the find wins
    do_reset(0, 0, 0);
    start(1'b0);
    wait_pulses("e2", 4);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_done("e2");
    check("e2_key", 32'(key_v[0]), 32'h000003);
    check("e2_kv",  32'(key_valid_v[0]), 32'd1);

    // en in the DONE cycle starts a new search at once
    en_v[0] = 1'b1;
    @(negedge clk);
    en_v = 3'b000;
    check("g_accept_rdy", 32'(rdy_v[0]), 32'd0);
    check("g_accept_kv",  32'(key_valid_v[0]), 32'd0);
    wait_done("g");
    check("g_pulses", 32'(n_pulse), 32'd8);
    check("g_key", 32'(key_v[0]), 32'h000003);
    check("g_kv",  32'(key_valid_v[0]), 32'd1);

    // arc4 not ready for 10 cycles; printable-range boundaries
    do_reset(0, 2, 10);
    start(1'b0);
    repeat (6) @(negedge clk);
    check("f_no_pulse", 32'(n_pulse), 32'd0);
    check("f_launch_rdy", 32'(rdy_v[0]), 32'd0);
    wait_done("f");
    check("f_pulses", 32'(n_pulse), 32'd2);
    check("f_try1", 32'(tried[1]), 32'h000001);
    check("f_key", 32'(key_v[0]), 32'h000001);
    check("f_kv",  32'(key_valid_v[0]), 32'd1);

    // Reset during WAIT_DONE of a second search
    do_reset(0, 0, 0);
    start(1'b0);
    wait_done("h1");
    start(1'b0);
    begin
      int n;
      n = 0;
      while (!(n_pulse >= 6 && pt_wren) && n < 600) begin
        @(negedge clk);
        n++;
      end
      check("h_in_run", 32'(n_pulse), 32'd6);
    end
    check("h_pre_key", 32'(key_v[0]), 32'h000003);
    rst_n = 1'b0;
    @(negedge clk);
    check("h_rdy",  32'(rdy_v[0]), 32'd1);
    check("h_key",  32'(key_v[0]), 32'd0);
    check("h_kv",   32'(key_valid_v[0]), 32'd0);
    check("h_a4en", 32'(arc4_en_v[0]), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
